// File: rtl/arith_rr_scheduler.sv
// arith_rr_scheduler: round-robin front end for a shared pipelined Y=(A+B)*(C-D)
// unit. It grants one requester per cycle and registers that requester's operands
// into the unit. A shadow tag pipeline follows each operation through the unit's
// latency, so every result comes back with the index of the requester that sent it.
module arith_rr_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int PIPE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_mask,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [8*NUM_REQ-1:0] req_c,
  input  logic [8*NUM_REQ-1:0] req_d,
  output logic [7:0]           unit_a,
  output logic [7:0]           unit_b,
  output logic [7:0]           unit_c,
  output logic [7:0]           unit_d,
  input  logic [15:0]          unit_y,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [15:0]          res_data,
  output logic                 busy,
  output logic [15:0]          issue_count
);

  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [ID_W:0]      cand;

  // Tag pipeline. Stage 0 is loaded on the issue edge, and stage PIPE_LAT lines up with unit_y.
  logic [PIPE_LAT:0]  sh_valid;
  logic [ID_W-1:0]    sh_id [PIPE_LAT+1];

  // Eligibility is gated with rst so that no grant is presented while reset is held.
  always_comb begin
    eligible = req_valid & req_mask & {NUM_REQ{enable & ~rst}};
  end

  // Round-robin search starting one past the last granted index, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && eligible[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;

  // Operand registers feed the unit. They load zeros on idle edges so the unit sees clean inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_a <= '0;
      unit_b <= '0;
      unit_c <= '0;
      unit_d <= '0;
    end else if (grant_any) begin
      unit_a <= req_a[8*grant_id +: 8];
      unit_b <= req_b[8*grant_id +: 8];
      unit_c <= req_c[8*grant_id +: 8];
      unit_d <= req_d[8*grant_id +: 8];
    end else begin
      unit_a <= '0;
      unit_b <= '0;
      unit_c <= '0;
      unit_d <= '0;
    end
  end

  // The pointer remembers the last grant, and the counter tallies every issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= ID_W'(NUM_REQ - 1);
      issue_count <= '0;
    end else if (grant_any) begin
      ptr         <= grant_id;
      issue_count <= issue_count + 16'd1;
    end
  end

  // Shift the tags in step with the unit. Reset clears them, which discards any operations in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid <= '0;
      for (int s = 0; s <= PIPE_LAT; s++) begin
        sh_id[s] <= '0;
      end
    end else begin
      sh_valid <= {sh_valid[PIPE_LAT-1:0], grant_any};
      sh_id[0] <= grant_any ? grant_id : '0;
      for (int s = 1; s <= PIPE_LAT; s++) begin
        sh_id[s] <= sh_id[s-1];
      end
    end
  end

  assign res_valid = sh_valid[PIPE_LAT];
  assign res_id    = sh_id[PIPE_LAT];
  assign res_data  = unit_y;
  assign busy      = grant_any | (|sh_valid);

endmodule
